// File: rtl/codeword_bank_loader.sv
// Double-buffered codeword table loader: streams DEPTH rows from a BANKS-wide ROM into a shadow map.
// Optional build macro CWL_AUTOLOAD_EN issues one load request right after reset release.
module codeword_bank_loader #(
    parameter  int ANTS    = 32,
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 64,
    parameter  int BANKS   = 2,
    parameter  int ROM_LAT = 4,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int ROW_W   = WIDTH * ANTS
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic                                    i_load_req,
    input  logic                                    i_swap,
    output logic                                    o_rom_rden,
    output logic [ADDR_W-1:0]                       o_rom_addr,
    input  logic [BANKS*ROW_W-1:0]                  i_rom_q,
    output logic [BANKS-1:0][DEPTH-1:0][ROW_W-1:0]  o_cw,
    output logic                                    o_tvalid,
    output logic                                    o_busy,
    output logic                                    o_load_done,
    output logic                                    o_swap_err,
    output logic                                    o_active_sel
);

    // state  | meaning
    // S_IDLE | waiting for a load request; swaps are accepted here only
    // S_READ | issuing ROM reads, one row per cycle
    // S_DRAIN| waiting for the last ROM_LAT rows to be captured
    // S_DONE | load complete; first load is promoted to active
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam int CNT_MAX = (DEPTH > ROM_LAT) ? DEPTH : ROM_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                active_sel_q, active_sel_d;
    logic                tvalid_q, tvalid_d;
    logic                shadow_valid_q, shadow_valid_d;
    logic                swap_err_q, swap_err_d;
    logic                swap_ok;
    logic                load_req;
    logic                shadow_sel;

    logic [1:0][BANKS-1:0][DEPTH-1:0][ROW_W-1:0] map_q;
    logic                vld_pipe_q [ROM_LAT];
    logic [ADDR_W-1:0]   idx_pipe_q [ROM_LAT];

`ifdef CWL_AUTOLOAD_EN
    logic auto_done_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) auto_done_q <= 1'b0;
        else         auto_done_q <= 1'b1;
    end

    assign load_req = i_load_req | ~auto_done_q;
`else
    assign load_req = i_load_req;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            addr_q         <= '0;
            active_sel_q   <= 1'b0;
            tvalid_q       <= 1'b0;
            shadow_valid_q <= 1'b0;
            swap_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            active_sel_q   <= active_sel_d;
            tvalid_q       <= tvalid_d;
            shadow_valid_q <= shadow_valid_d;
            swap_err_q     <= swap_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        active_sel_d   = active_sel_q;
        tvalid_d       = tvalid_q;
        shadow_valid_d = shadow_valid_q;
        swap_ok        = i_swap && shadow_valid_q && (state_q == S_IDLE);
        swap_err_d     = i_swap && !swap_ok;

        case (state_q)
            S_IDLE: begin
                // Swap is applied first so a simultaneous load fills the old active map.
                if (swap_ok) begin
                    active_sel_d   = ~active_sel_q;
                    shadow_valid_d = 1'b0;
                end
                if (load_req) begin
                    state_d        = S_READ;
                    cnt_d          = CNT_W'(DEPTH - 1);
                    addr_d         = '0;
                    shadow_valid_d = 1'b0;
                end
            end
            S_READ: begin
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(ROM_LAT - 1);
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!tvalid_q) begin
                    active_sel_d = ~active_sel_q;
                    tvalid_d     = 1'b1;
                end else begin
                    shadow_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign shadow_sel = ~active_sel_q;

    // Rows return ROM_LAT cycles after issue; the delay line tags each with its row index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            map_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                vld_pipe_q[i] <= 1'b0;
                idx_pipe_q[i] <= '0;
            end
        end else begin
            vld_pipe_q[0] <= o_rom_rden;
            idx_pipe_q[0] <= addr_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                idx_pipe_q[i] <= idx_pipe_q[i-1];
            end
            if (vld_pipe_q[ROM_LAT-1]) begin
                for (int b = 0; b < BANKS; b++) begin
                    map_q[shadow_sel][b][idx_pipe_q[ROM_LAT-1]] <= i_rom_q[b*ROW_W +: ROW_W];
                end
            end
        end
    end

    assign o_rom_rden   = (state_q == S_READ);
    assign o_rom_addr   = addr_q;
    assign o_busy       = (state_q == S_READ) || (state_q == S_DRAIN);
    assign o_load_done  = (state_q == S_DONE);
    assign o_swap_err   = swap_err_q;
    assign o_tvalid     = tvalid_q;
    assign o_active_sel = active_sel_q;
    assign o_cw         = map_q[active_sel_q];

endmodule

// File: tb/tb_codeword_bank_loader.sv
// Directed bench for codeword_bank_loader at default parameters with a ROM_LAT-stage ROM model.
module tb_codeword_bank_loader;

    localparam int ANTS    = 32;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 64;
    localparam int BANKS   = 2;
    localparam int ROM_LAT = 4;
    localparam int ADDR_W  = 6;
    localparam int ROW_W   = WIDTH * ANTS;

    typedef logic [BANKS-1:0][DEPTH-1:0][ROW_W-1:0] cw_t;

    logic               i_clk;
    logic               i_reset;
    logic               i_load_req;
    logic               i_swap;
    logic               o_rom_rden;
    logic [ADDR_W-1:0]  o_rom_addr;
    logic [BANKS*ROW_W-1:0] i_rom_q;
    cw_t                o_cw;
    logic               o_tvalid;
    logic               o_busy;
    logic               o_load_done;
    logic               o_swap_err;
    logic               o_active_sel;

    int checks = 0;
    int errors = 0;
    int rom_tag = 0;
    logic [ADDR_W-1:0] rom_pipe [ROM_LAT];

    codeword_bank_loader #(
        .ANTS(ANTS), .WIDTH(WIDTH), .DEPTH(DEPTH), .BANKS(BANKS), .ROM_LAT(ROM_LAT)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_load_req(i_load_req), .i_swap(i_swap),
        .o_rom_rden(o_rom_rden), .o_rom_addr(o_rom_addr), .i_rom_q(i_rom_q), .o_cw(o_cw),
        .o_tvalid(o_tvalid), .o_busy(o_busy), .o_load_done(o_load_done),
        .o_swap_err(o_swap_err), .o_active_sel(o_active_sel)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [ROW_W-1:0] rom_row(input int tag, input int b, input int k);
        logic [ROW_W-1:0] r;
        logic [7:0] hdr;
        hdr = (tag != 0) ? 8'hC3 : 8'h5A;
        for (int a = 0; a < ANTS; a++) r[a*WIDTH +: WIDTH] = {hdr, 8'(b), 8'(k), 8'(a)};
        return r;
    endfunction

    function automatic cw_t exp_map(input int tag);
        cw_t m;
        for (int b = 0; b < BANKS; b++)
            for (int k = 0; k < DEPTH; k++) m[b][k] = rom_row(tag, b, k);
        return m;
    endfunction

    function automatic int diff_rows(input cw_t x, input cw_t y);
        int n = 0;
        for (int b = 0; b < BANKS; b++)
            for (int k = 0; k < DEPTH; k++) if (x[b][k] !== y[b][k]) n++;
        return n;
    endfunction

    // ROM model: registered address pipeline, data valid ROM_LAT cycles after issue
    always @(posedge i_clk) begin
        rom_pipe[0] <= o_rom_addr;
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end

    always_comb begin
        i_rom_q = '0;
        for (int b = 0; b < BANKS; b++)
            i_rom_q[b*ROW_W +: ROW_W] = rom_row(rom_tag, b, int'(rom_pipe[ROM_LAT-1]));
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cw(input string tag, input cw_t exp);
        checks++;
        assert (o_cw === exp) else begin
            errors++;
            $error("FAIL %s: observed o_cw[0][0] low word=%0h expected=%0h, rows differing=%0d",
                   tag, o_cw[0][0][31:0], exp[0][0][31:0], diff_rows(o_cw, exp));
        end
    endtask

    // Runs one load from cycle 0 to the DONE cycle; optional swap attempt at swap_cyc.
    task automatic do_load(input int tag, input int swap_cyc);
        rom_tag    = tag;
        i_load_req = 1'b1;
        for (int c = 1; c <= DEPTH + ROM_LAT + 1; c++) begin
            tick();
            i_load_req = 1'b0;
            chk("rden", o_rom_rden, (c <= DEPTH));
            if (c <= DEPTH) chk("addr", o_rom_addr, c - 1);
            chk("busy", o_busy, (c <= DEPTH + ROM_LAT));
            chk("load_done", o_load_done, (c == DEPTH + ROM_LAT + 1));
            if (swap_cyc > 0 && c == swap_cyc + 1) chk("swap_err_busy", o_swap_err, 1);
            i_swap = (c == swap_cyc);
        end
        i_swap = 1'b0;
    endtask

    initial begin : main
        int dones;
        int starts;
        int mono_bad;
        int start_cyc [2];
        logic prev_rden;
        logic [ADDR_W-1:0] prev_addr;

        i_reset    = 1'b1;
        i_load_req = 1'b0;
        i_swap     = 1'b0;
        repeat (3) tick();
        i_reset = 1'b0;

        chk("rst_rden", o_rom_rden, 0);
        chk("rst_addr", o_rom_addr, 0);
        chk("rst_tvalid", o_tvalid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_load_done, 0);
        chk("rst_swap_err", o_swap_err, 0);
        chk("rst_active", o_active_sel, 0);
        chk_cw("rst_cw", '0);

        // swap with no valid shadow
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        chk("swap_noshadow_err", o_swap_err, 1);
        chk("swap_noshadow_active", o_active_sel, 0);
        tick();
        chk("swap_err_pulse", o_swap_err, 0);

        // first load promotes automatically
        do_load(0, 0);
        tick();
        chk("first_tvalid", o_tvalid, 1);
        chk("first_active", o_active_sel, 1);
        chk("first_done_low", o_load_done, 0);
        chk_cw("first_cw_f", exp_map(0));

        // shadow_valid stayed 0 after promotion
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        chk("promo_swap_err", o_swap_err, 1);
        chk("promo_swap_active", o_active_sel, 1);
        chk_cw("promo_swap_cw", exp_map(0));

        // second table into shadow, swap attempted mid-load
        do_load(1, 10);
        tick();
        chk("second_active", o_active_sel, 1);
        chk("second_tvalid", o_tvalid, 1);
        chk_cw("second_cw_still_f", exp_map(0));
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        chk("swap_active", o_active_sel, 0);
        chk("swap_no_err", o_swap_err, 0);
        chk_cw("swap_cw_g", exp_map(1));
        i_swap = 1'b1;
        tick();
        i_swap = 1'b0;
        chk("reswap_err", o_swap_err, 1);
        chk("reswap_active", o_active_sel, 0);
        chk_cw("reswap_cw_g", exp_map(1));

        // held request: back-to-back loads, released after the second done
        rom_tag    = 0;
        i_load_req = 1'b1;
        dones      = 0;
        starts     = 0;
        mono_bad   = 0;
        start_cyc[0] = -1;
        start_cyc[1] = -1;
        prev_rden  = 1'b0;
        prev_addr  = '0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (o_load_done) dones++;
            if (o_rom_rden) begin
                if (!prev_rden) begin
                    if (starts < 2) start_cyc[starts] = c;
                    starts++;
                    if (o_rom_addr !== '0) mono_bad++;
                end else if (o_rom_addr !== prev_addr + 1'b1) begin
                    mono_bad++;
                end
                if (o_load_done) mono_bad++;
            end
            prev_rden = o_rom_rden;
            prev_addr = o_rom_addr;
            if (dones == 2) i_load_req = 1'b0;
        end
        chk("held_dones", dones, 2);
        chk("held_starts", starts, 2);
        chk("held_first_start", start_cyc[0], 1);
        chk("held_second_start", start_cyc[1], DEPTH + ROM_LAT + 3);
        chk("held_monotonic", mono_bad, 0);

        // reset in the middle of a load
        rom_tag    = 1;
        i_load_req = 1'b1;
        tick();
        i_load_req = 1'b0;
        for (int c = 2; c <= 30; c++) tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("midrst_rden", o_rom_rden, 0);
        chk("midrst_addr", o_rom_addr, 0);
        chk("midrst_tvalid", o_tvalid, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_done", o_load_done, 0);
        chk("midrst_active", o_active_sel, 0);
        chk_cw("midrst_cw", '0);
        repeat (6) tick();
        chk_cw("midrst_inflight_cw", '0);
        chk("midrst_tvalid_late", o_tvalid, 0);

        do_load(0, 0);
        tick();
        chk("postrst_tvalid", o_tvalid, 1);
        chk("postrst_active", o_active_sel, 1);
        chk_cw("postrst_cw_f", exp_map(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
